// File: rtl/fft_pkg.sv
// Shared FFT sizing for the serializer/deserializer pair.
// Latency: n/a (constants and a compile-time helper only).
// Backpressure: n/a.
//
// Contents: default component width, channel count, frame length, and the
// counter widths derived from them.
package fft_pkg;

    localparam int FFT_NB_DATA  = 12;
    localparam int FFT_N_CH     = 4;
    localparam int FFT_N_POINTS = 32;

    // Counter width that still works when a range collapses to one value.
    function automatic int fft_ctr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FFT_LANE_W = fft_ctr_w(FFT_N_CH);
    localparam int FFT_VEC_W  = fft_ctr_w(FFT_N_POINTS / FFT_N_CH);

endpackage

// File: rtl/fft_deserializer.sv
// Serial-to-parallel: groups four consecutive complex samples into one vector.
// Latency: 1 clock from the 4th accepted sample of a vector to o_valid.
// Backpressure: none; i_enable=0 freezes all state and forces the pulses low.
//
// Ports: i_clk, i_rst (sync, active high), i_enable, i_valid, i_sof,
//        i_din {re,im}; o_dout_ch0..3 (ch0 earliest), o_valid, o_sof, o_err.
module fft_deserializer
    import fft_pkg::*;
#(
    parameter int NB_DATA  = FFT_NB_DATA,
    parameter int N_CH     = FFT_N_CH,
    parameter int N_POINTS = FFT_N_POINTS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic                 i_sof,
    input  logic [2*NB_DATA-1:0] i_din,
    output logic [2*NB_DATA-1:0] o_dout_ch0,
    output logic [2*NB_DATA-1:0] o_dout_ch1,
    output logic [2*NB_DATA-1:0] o_dout_ch2,
    output logic [2*NB_DATA-1:0] o_dout_ch3,
    output logic                 o_valid,
    output logic                 o_sof,
    output logic                 o_err
);

    localparam int N_VEC  = N_POINTS / N_CH;
    localparam int LANE_W = fft_ctr_w(N_CH);
    localparam int VEC_W  = fft_ctr_w(N_VEC);

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(N_CH - 1);
    localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(N_VEC - 1);

    logic [LANE_W-1:0]    lane_q;
    logic [VEC_W-1:0]     vec_q;
    // The last lane never needs holding: it is forwarded straight into the
    // output register on the cycle it arrives.
    logic [2*NB_DATA-1:0] lane_reg [N_CH-1];

    logic accept;
    assign accept = i_enable & i_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lane_q     <= '0;
            vec_q      <= '0;
            for (int i = 0; i < N_CH - 1; i++) begin
                lane_reg[i] <= '0;
            end
            o_dout_ch0 <= '0;
            o_dout_ch1 <= '0;
            o_dout_ch2 <= '0;
            o_dout_ch3 <= '0;
            o_valid    <= 1'b0;
            o_sof      <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            // Pulses default low; data outputs hold until the next vector.
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_err   <= 1'b0;
            if (accept) begin
                if (i_sof) begin
                    // Realign: this sample opens vector 0 of a new frame.
                    // Anything half-built is dropped and flagged.
                    lane_reg[0] <= i_din;
                    lane_q      <= LANE_W'(1);
                    vec_q       <= '0;
                    o_err       <= (lane_q != '0);
                end else if (lane_q == LANE_LAST) begin
                    o_dout_ch0 <= lane_reg[0];
                    o_dout_ch1 <= lane_reg[1];
                    o_dout_ch2 <= lane_reg[2];
                    o_dout_ch3 <= i_din;
                    o_valid    <= 1'b1;
                    o_sof      <= (vec_q == '0);
                    lane_q     <= '0;
                    vec_q      <= (vec_q == VEC_LAST) ? '0 : vec_q + 1'b1;
                end else begin
                    lane_reg[lane_q] <= i_din;
                    lane_q           <= lane_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_deserializer.sv
// Scoreboarded bench for fft_deserializer.
// Latency: checks o_valid/o_err land exactly one clock after the causing sample.
// Backpressure: n/a; enable gaps and valid gaps are part of the stimulus.
module tb_fft_deserializer;
    import fft_pkg::*;

    localparam int NB  = FFT_NB_DATA;
    localparam int SW  = 2 * NB;
    localparam int NV  = FFT_N_POINTS / FFT_N_CH;

    typedef struct packed {
        logic [3:0][SW-1:0] d;   // d[0] = earliest sample
        logic               sof;
        int                 due;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          val = 1'b0;
    logic          sof = 1'b0;
    logic [SW-1:0] din = '0;
    logic [SW-1:0] ch0, ch1, ch2, ch3;
    logic          o_valid, o_sof, o_err;

    fft_deserializer dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (en),
        .i_valid    (val),
        .i_sof      (sof),
        .i_din      (din),
        .o_dout_ch0 (ch0),
        .o_dout_ch1 (ch1),
        .o_dout_ch2 (ch2),
        .o_dout_ch3 (ch3),
        .o_valid    (o_valid),
        .o_sof      (o_sof),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    logic rst_at_edge = 1'b1;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a frame is a stream of samples chopped into groups of
    // four; a start-of-frame restarts both the group and the frame position.
    vec_t          exp_q[$];
    int            err_q[$];
    logic [SW-1:0] pend[$];
    int            vidx = 0;

    task automatic drv(input logic e, input logic v, input logic s, input logic [SW-1:0] d);
        vec_t x;
        en = e; val = v; sof = s; din = d;
        if (e && v) begin
            if (s) begin
                if (pend.size() != 0) err_q.push_back(cyc + 1);
                pend.delete();
                vidx = 0;
            end
            pend.push_back(d);
            if (pend.size() == 4) begin
                for (int i = 0; i < 4; i++) x.d[i] = pend[i];
                x.sof = (vidx == 0);
                x.due = cyc + 1;
                exp_q.push_back(x);
                vidx = (vidx + 1) % NV;
                pend.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; en = 1'b0; val = 1'b0; sof = 1'b0;
        pend.delete();
        exp_q.delete();
        err_q.delete();
        vidx = 0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b1, 1'b0, 1'b0, SW'($urandom));
    endtask

    // Monitor: pops the scoreboard whenever an output is due and checks that
    // nothing appears when nothing is due.
    logic [3:0][SW-1:0] last = '0;
    logic [3:0][SW-1:0] outv;
    assign outv = {ch3, ch2, ch1, ch0};

    always @(negedge clk) begin
        vec_t e;
        if (rst_at_edge) begin
            chk("reset_dout", 128'(outv), 128'(0));
            chk("reset_flags", 128'({o_valid, o_sof, o_err}), 128'(0));
            last = '0;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("o_valid", 128'(o_valid), 128'(1));
                chk("vector", 128'(outv), 128'(e.d));
                chk("o_sof", 128'(o_sof), 128'(e.sof));
                last = e.d;
            end else begin
                chk("no_valid", 128'(o_valid), 128'(0));
                chk("hold", 128'(outv), 128'(last));
            end
            if (err_q.size() > 0 && err_q[0] == cyc) begin
                void'(err_q.pop_front());
                chk("o_err", 128'(o_err), 128'(1));
            end else begin
                chk("no_err", 128'(o_err), 128'(0));
            end
        end
    end

    logic [SW-1:0] frame [2][FFT_N_POINTS];

    initial begin
        do_reset(3);

        // Contiguous frame 0..31 with start-of-frame on sample 0.
        for (int i = 0; i < 32; i++) drv(1'b1, 1'b1, (i == 0), SW'(i));
        idle(3);

        // Valid toggling every cycle.
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 1'b1, 1'b0, SW'(i));
            drv(1'b1, 1'b0, 1'b0, SW'($urandom));
        end
        idle(2);

        // Partial vector abandoned by a new start-of-frame.
        for (int i = 0; i < 3; i++) drv(1'b1, 1'b1, 1'b0, SW'(i));
        drv(1'b1, 1'b1, 1'b1, SW'(100));
        for (int i = 101; i < 104; i++) drv(1'b1, 1'b1, 1'b0, SW'(i));
        idle(2);

        // Enable dropped mid-vector with valid still high.
        drv(1'b1, 1'b1, 1'b0, SW'(0));
        drv(1'b1, 1'b1, 1'b0, SW'(1));
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 1'b1, (i == 2), SW'($urandom));
            chk("disabled_valid", 128'(o_valid), 128'(0));
        end
        drv(1'b1, 1'b1, 1'b0, SW'(2));
        drv(1'b1, 1'b1, 1'b0, SW'(3));
        idle(2);

        // Reset with a partial vector pending, then an immediate new vector.
        drv(1'b1, 1'b1, 1'b0, SW'(0));
        drv(1'b1, 1'b1, 1'b0, SW'(1));
        do_reset(2);
        for (int i = 8; i < 12; i++) drv(1'b1, 1'b1, 1'b0, SW'(i));
        idle(2);

        // Two back-to-back random frames as a serializer would emit them.
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < FFT_N_POINTS; i++) frame[f][i] = SW'($urandom);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < FFT_N_POINTS; i++)
                drv(1'b1, 1'b1, (i == 0), frame[f][i]);
        idle(2);

        // Random mix of enables, gaps, realignments and data.
        for (int i = 0; i < 600; i++)
            drv(($urandom % 8) != 0, ($urandom % 4) != 0,
                ($urandom % 20) == 0, SW'($urandom));
        idle(4);

        chk("drain_vectors", 128'(exp_q.size()), 128'(0));
        chk("drain_errs", 128'(err_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft_deserializer.md
FFT_DESERIALIZER -- requirements
Module: fft_deserializer

Interface
REQ-001 SHALL have parameter NB_DATA, default 12, bit width of each real and imaginary component.
REQ-002 SHALL have parameter N_CH, default 4, number of parallel output channels; fixed at 4 in this revision.
REQ-003 SHALL have parameter N_POINTS, default 32, FFT frame length in samples; a multiple of N_CH.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_enable  input  1  global enable; low freezes all state.
REQ-007 SHALL have port i_valid  input  1  i_din carries a sample this cycle.
REQ-008 SHALL have port i_sof  input  1  start of frame; qualified by i_valid; marks sample 0 of a frame.
REQ-009 SHALL have port i_din  input  2*NB_DATA  serial complex sample, {re, im}.
REQ-010 SHALL have ports o_dout_ch0..o_dout_ch3  output  2*NB_DATA each  parallel samples, ch0 = earliest.
REQ-011 SHALL have port o_valid  output  1  one-cycle pulse; the four channels are a new vector.
REQ-012 SHALL have port o_sof  output  1  high with o_valid when the vector is vector 0 of a frame.
REQ-013 SHALL have port o_err  output  1  one-cycle pulse; a partial vector was discarded.

Function
REQ-014 SHALL accept a sample only when i_enable=1 and i_valid=1.
REQ-015 SHALL keep a 2-bit lane counter (0..3); each accepted sample is stored in lane register [lane], and the counter then increments, wrapping 3->0.
REQ-016 SHALL register all four lanes to o_dout_ch0..3 and assert o_valid one cycle after the accepted sample with lane=3; latency = 1 clock from the 4th sample.
REQ-017 SHALL hold o_dout_ch0..3 stable between o_valid pulses.
REQ-018 SHALL keep a vector counter 0..N_POINTS/N_CH-1 that increments on each o_valid and wraps to 0; o_sof=1 iff the emitted vector index is 0.
REQ-019 SHALL, for an accepted sample with i_sof=1, store it in lane 0, set lane to 1, and set the vector index of the vector being built to 0.
REQ-020 SHALL, if i_sof is accepted while lane!=0, discard the partial lanes and pulse o_err one cycle later; o_valid is not asserted for the discarded vector.
REQ-021 SHALL treat i_sof with lane=0 as a normal realignment with no o_err.
REQ-022 SHALL ignore i_sof when i_valid=0 or i_enable=0.
REQ-023 SHALL, with i_enable=0, freeze the lane and vector counters and the lane registers, hold the outputs, and force o_valid, o_sof and o_err to 0.
REQ-024 SHALL allow gaps (i_valid=0) between samples of one vector without loss; partial lanes are retained.
REQ-025 SHALL allow back-to-back vectors: o_valid may be asserted on consecutive groups of 4 samples with no idle cycle.

Reset
REQ-026 SHALL, on i_rst=1 at a rising edge, set the lane counter, vector counter, lane registers, o_dout_ch0..3, o_valid, o_sof and o_err to 0.
REQ-027 SHALL give i_rst priority over i_enable, i_valid and i_sof; a partial vector pending at reset is dropped silently (no o_err).
REQ-028 SHALL accept a sample in the first cycle after i_rst deasserts.

Structure
REQ-029 SHALL take NB_DATA, N_CH, N_POINTS and the derived widths (lane counter width = clog2(N_CH), vector counter width = clog2(N_POINTS/N_CH)) from the shared FFT package fft_pkg, which is also used by fft_serializer.
REQ-030 SHALL be one flat module with no sub-modules; the lane and vector counters live inline.

Verification
REQ-031 SHALL verify: reset; then 32 contiguous samples 0..31, i_sof on sample 0 -> 8 o_valid pulses with vectors {0,1,2,3}..{28,29,30,31}, o_sof on the first only, each 1 cycle after sample 4k+3.
REQ-032 SHALL verify: samples 0..7 with i_valid toggling every cycle -> two vectors {0,1,2,3},{4,5,6,7}, with no loss or duplicates.
REQ-033 SHALL verify: samples 0,1,2, then i_sof with sample 100, then 101..103 -> o_err pulse, one vector {100,101,102,103} with o_sof=1, and no vector containing 0..2.
REQ-034 SHALL verify: i_enable dropped for 5 cycles after sample 1 with i_valid held high -> those cycles ignored, then samples 2,3 complete vector {0,1,2,3}, and o_valid=0 while disabled.
REQ-035 SHALL verify: i_rst asserted after samples 0,1 -> all outputs 0 and no o_err; then samples 8..11 -> vector {8,9,10,11}.
REQ-036 SHALL verify: loopback fft_serializer -> fft_deserializer with two 32-sample frames -> the output vectors equal the serializer inputs, in order.
